// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit stuffing, NRZI encoding and D+/D- pad drive,
// including the SE0-SE0-J end of packet. A small bit FIFO absorbs the extra
// bit times that stuffing inserts, because upstream generators never stall.
//
// Upstream interface: there is no valid/ready handshake. checkData is a
// one-cycle bit-time strobe shared with the generators. On a strobe cycle
// txOE=1/txEop=0 means "txBit is the next raw bit", and txOE=1/txEop=1 means
// "end the packet". txOE=0 in the middle of a packet, before any EOP request,
// aborts it. Bits that cannot be accepted are dropped and flagged in
// stuffOverflow.
//
// dbgState exposes the FSM state for debug and checkers.
module usb_tx_line_encoder #(
    parameter bit LOW_SPEED  = 1'b0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       useClk,
    input  logic       rst,
    input  logic       checkData,
    input  logic       txBit,
    input  logic       txOE,
    input  logic       txEop,
    output logic       dpOut,
    output logic       dmOut,
    output logic       dOE,
    output logic       txBusy,
    output logic       stuffOverflow,
    output logic       txAbort,
    output logic [2:0] dbgState
);

    // Pointer width; a depth of 2 still needs a 1-bit pointer.
    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW:0]   CNT_ONE    = (PW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        EOP_SE0_1 = 3'd2,
        EOP_SE0_2 = 3'd3,
        EOP_J     = 3'd4
    } stateT;

    stateT                 stateQ, stateD;
    logic [FIFO_DEPTH-1:0] fifoMemQ, fifoMemD;
    logic [PW-1:0]         rdPtrQ, rdPtrD;
    logic [PW-1:0]         wrPtrQ, wrPtrD;
    logic [PW:0]           countQ, countD;
    logic [2:0]            onesQ, onesD;
    logic                  eopPendQ, eopPendD;
    // lineJQ: 1 = line idles at J, 0 = line at K. se0Q overrides both pins low.
    logic                  lineJQ, lineJD;
    logic                  se0Q, se0D;
    logic                  oeQ, oeD;
    logic                  busyQ, busyD;
    logic                  ovfQ, ovfD;
    logic                  abortQ, abortD;

    logic pushReq;
    logic eopReq;
    logic fifoEmpty;
    logic fifoFull;
    logic headBit;
    logic doPush;
    logic doPop;
    logic doFlush;
    logic pushOk;

    // New raw bits are accepted only until an EOP request has been latched.
    assign pushReq   = txOE & ~txEop & ~eopPendQ;
    assign eopReq    = txOE &  txEop & ~eopPendQ;
    assign fifoEmpty = (countQ == '0);
    assign fifoFull  = (countQ == FULL_COUNT);
    assign headBit   = fifoMemQ[rdPtrQ];

    // Next-state, line encoding and FIFO bookkeeping for one strobe.
    always_comb begin
        stateD   = stateQ;
        fifoMemD = fifoMemQ;
        rdPtrD   = rdPtrQ;
        wrPtrD   = wrPtrQ;
        countD   = countQ;
        onesD    = onesQ;
        eopPendD = eopPendQ;
        lineJD   = lineJQ;
        se0D     = se0Q;
        oeD      = oeQ;
        busyD    = busyQ;
        ovfD     = ovfQ;
        abortD   = 1'b0;   // txAbort is a single useClk pulse, strobe or not
        doPush   = 1'b0;
        doPop    = 1'b0;
        doFlush  = 1'b0;
        pushOk   = 1'b0;

        if (checkData) begin
            unique case (stateQ)
                IDLE: begin
                    // First raw bit opens the packet; pins follow one strobe later.
                    if (pushReq) begin
                        stateD = DATA;
                        doPush = 1'b1;
                        lineJD = 1'b1;
                        se0D   = 1'b0;
                        onesD  = 3'd0;
                        oeD    = 1'b0;
                        busyD  = 1'b1;
                        ovfD   = 1'b0;
                    end
                end

                DATA: begin
                    if (!txOE && !eopPendQ) begin
                        // Upstream vanished without an EOP: release the pads.
                        stateD  = IDLE;
                        doFlush = 1'b1;
                        oeD     = 1'b0;
                        lineJD  = 1'b1;
                        se0D    = 1'b0;
                        onesD   = 3'd0;
                        busyD   = 1'b0;
                        abortD  = 1'b1;
                    end else begin
                        oeD    = 1'b1;
                        doPush = pushReq;
                        if (eopReq) begin
                            eopPendD = 1'b1;
                        end
                        // Decisions use the FIFO contents before this strobe's push.
                        if (onesQ == 3'd6) begin
                            lineJD = ~lineJQ;   // stuff bit
                            onesD  = 3'd0;
                        end else if (!fifoEmpty) begin
                            doPop = 1'b1;
                            if (headBit) begin
                                onesD = onesQ + 3'd1;
                            end else begin
                                lineJD = ~lineJQ;
                                onesD  = 3'd0;
                            end
                        end else if (eopPendQ) begin
                            stateD = EOP_SE0_1;
                            se0D   = 1'b1;
                        end
                        // Underflow without a pending EOP simply holds the line.
                    end
                end

                EOP_SE0_1: begin
                    stateD = EOP_SE0_2;
                end

                EOP_SE0_2: begin
                    stateD = EOP_J;
                    se0D   = 1'b0;
                    lineJD = 1'b1;
                end

                EOP_J: begin
                    stateD   = IDLE;
                    doFlush  = 1'b1;
                    oeD      = 1'b0;
                    busyD    = 1'b0;
                    eopPendD = 1'b0;
                    onesD    = 3'd0;
                end

                default: begin
                    stateD = IDLE;
                end
            endcase
        end

        if (doFlush) begin
            rdPtrD = '0;
            wrPtrD = '0;
            countD = '0;
        end else begin
            // A full FIFO still accepts a push when the same strobe pops.
            pushOk = doPush && (!fifoFull || doPop);
            if (doPush && !pushOk) begin
                ovfD = 1'b1;
            end
            if (pushOk) begin
                fifoMemD[wrPtrQ] = txBit;
                wrPtrD           = wrPtrQ + PTR_ONE;
            end
            if (doPop) begin
                rdPtrD = rdPtrQ + PTR_ONE;
            end
            if (pushOk && !doPop) begin
                countD = countQ + CNT_ONE;
            end else if (!pushOk && doPop) begin
                countD = countQ - CNT_ONE;
            end
        end
    end

    // State register; reset releases the pad and returns the line to J.
    always_ff @(posedge useClk) begin
        if (rst) begin
            stateQ   <= IDLE;
            fifoMemQ <= '0;
            rdPtrQ   <= '0;
            wrPtrQ   <= '0;
            countQ   <= '0;
            onesQ    <= 3'd0;
            eopPendQ <= 1'b0;
            lineJQ   <= 1'b1;
            se0Q     <= 1'b0;
            oeQ      <= 1'b0;
            busyQ    <= 1'b0;
            ovfQ     <= 1'b0;
            abortQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            fifoMemQ <= fifoMemD;
            rdPtrQ   <= rdPtrD;
            wrPtrQ   <= wrPtrD;
            countQ   <= countD;
            onesQ    <= onesD;
            eopPendQ <= eopPendD;
            lineJQ   <= lineJD;
            se0Q     <= se0D;
            oeQ      <= oeD;
            busyQ    <= busyD;
            ovfQ     <= ovfD;
            abortQ   <= abortD;
        end
    end

    // J on full speed is dp=1; low speed swaps the polarity.
    assign dpOut         = se0Q ? 1'b0 :  (lineJQ ^ LOW_SPEED);
    assign dmOut         = se0Q ? 1'b0 : ~(lineJQ ^ LOW_SPEED);
    assign dOE           = oeQ;
    assign txBusy        = busyQ;
    assign stuffOverflow = ovfQ;
    assign txAbort       = abortQ;
    assign dbgState      = stateQ;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder (full speed, 4-entry FIFO).
// Pin codes are {dOE, dp, dm}: J=110, K=101, SE0=100, released=010.
module tb_usb_tx_line_encoder;

    logic       useClk;
    logic       rst;
    logic       checkData;
    logic       txBit;
    logic       txOE;
    logic       txEop;
    logic       dpOut;
    logic       dmOut;
    logic       dOE;
    logic       txBusy;
    logic       stuffOverflow;
    logic       txAbort;
    logic [2:0] dbgState;

    localparam logic [2:0] PIN_J   = 3'b110;
    localparam logic [2:0] PIN_K   = 3'b101;
    localparam logic [2:0] PIN_SE0 = 3'b100;
    localparam logic [2:0] PIN_OFF = 3'b010;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [2:0] expQ[$];
    logic [2:0] obsPins;
    logic [2:0] obsPinsLate;
    logic       obsBusy;
    logic       obsOvf;
    logic       obsAbort;
    logic       obsAbortLate;

    usb_tx_line_encoder #(
        .LOW_SPEED (1'b0),
        .FIFO_DEPTH(4)
    ) dut (
        .useClk       (useClk),
        .rst          (rst),
        .checkData    (checkData),
        .txBit        (txBit),
        .txOE         (txOE),
        .txEop        (txEop),
        .dpOut        (dpOut),
        .dmOut        (dmOut),
        .dOE          (dOE),
        .txBusy       (txBusy),
        .stuffOverflow(stuffOverflow),
        .txAbort      (txAbort),
        .dbgState     (dbgState)
    );

    // Clock
    initial begin
        useClk = 1'b0;
        forever #5 useClk = ~useClk;
    end

    // Time bound for the whole run
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", passCount, checkCount);
        $fatal(1, "time limit");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs === expv) begin
            passCount++;
        end else begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One strobe: drive inputs, sample right after the strobe edge and again
    // after one non-strobe clock.
    task automatic strobe(input logic oe, input logic eop, input logic b);
        @(negedge useClk);
        txOE      = oe;
        txEop     = eop;
        txBit     = b;
        checkData = 1'b1;
        @(negedge useClk);
        checkData = 1'b0;
        obsPins   = {dOE, dpOut, dmOut};
        obsBusy   = txBusy;
        obsOvf    = stuffOverflow;
        obsAbort  = txAbort;
        @(negedge useClk);
        obsPinsLate  = {dOE, dpOut, dmOut};
        obsAbortLate = txAbort;
    endtask

    // Queue expected pin codes from a string: K, J, 0 (SE0), anything else released.
    task automatic expStr(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "K":     expQ.push_back(PIN_K);
                "J":     expQ.push_back(PIN_J);
                "0":     expQ.push_back(PIN_SE0);
                default: expQ.push_back(PIN_OFF);
            endcase
        end
    endtask

    task automatic strobeCheck(input string tag, input int idx, input logic oe, input logic eop,
                               input logic b);
        logic [2:0] e;
        strobe(oe, eop, b);
        e = PIN_OFF;
        if (expQ.size() > 0) e = expQ.pop_front();
        checkVal($sformatf("%s pins s%0d", tag, idx), 32'(obsPins), 32'(e));
        checkVal($sformatf("%s hold s%0d", tag, idx), 32'(obsPinsLate), 32'(e));
    endtask

    // Full packet: bits pushed in written order, 3 EOP strobes, then idle strobes.
    task automatic runPacket(input string tag, input logic [63:0] bits, input int nBits,
                             input string expS);
        int s;
        int guard;
        expQ.delete();
        expStr(expS);
        strobe(1'b1, 1'b0, bits[nBits-1]);
        checkVal({tag, " start pins"}, 32'(obsPins), 32'(PIN_OFF));
        checkVal({tag, " start busy"}, 32'(obsBusy), 1);
        s = 1;
        for (int i = nBits - 2; i >= 0; i--) begin
            strobeCheck(tag, s, 1'b1, 1'b0, bits[i]);
            s++;
        end
        for (int i = 0; i < 3; i++) begin
            strobeCheck(tag, s, 1'b1, 1'b1, 1'b0);
            s++;
        end
        guard = 0;
        while (expQ.size() > 0 && guard < 40) begin
            strobeCheck(tag, s, 1'b0, 1'b0, 1'b0);
            s++;
            guard++;
        end
        checkVal({tag, " drained"}, 32'(expQ.size()), 0);
        checkVal({tag, " busy end"}, 32'(obsBusy), 0);
        expQ.delete();
    endtask

    initial begin
        int se0Seen;
        int ovfDropped;
        int guard;

        rst       = 1'b1;
        checkData = 1'b0;
        txBit     = 1'b0;
        txOE      = 1'b0;
        txEop     = 1'b0;
        repeat (3) @(negedge useClk);
        rst = 1'b0;
        checkVal("reset pins", 32'({dOE, dpOut, dmOut}), 32'(PIN_OFF));
        checkVal("reset busy", 32'(txBusy), 0);
        checkVal("reset ovf", 32'(stuffOverflow), 0);
        checkVal("reset abort", 32'(txAbort), 0);
        checkVal("reset state", 32'(dbgState), 0);

        // txOE low in IDLE is not an event
        strobe(1'b0, 1'b0, 1'b1);
        checkVal("idle pins", 32'(obsPins), 32'(PIN_OFF));
        checkVal("idle abort", 32'(obsAbort), 0);
        checkVal("idle busy", 32'(obsBusy), 0);

        // Sync, PID, 16 zeros
        runPacket("pkt1", 64'({8'b00000001, 8'b11010010, 16'h0000}), 32,
                  {"KJKJKJKK", "KKJJKJJK", "JKJKJKJKJKJKJKJK", "00J", "i"});

        // 0 then eight 1s: stuff toggle after the sixth 1
        runPacket("stuff8", 64'(9'b011111111), 9, {"KKKKKKK", "J", "JJ", "00J", "i"});

        // 0 then six 1s: owed stuff bit right before SE0
        runPacket("stuff6", 64'(7'b0111111), 7, {"KKKKKKK", "J", "00J", "i"});

        // 0 then 40 ones: stuffs at strobes 8,15,22,29; the 4th finds the FIFO full
        strobe(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            strobe(1'b1, 1'b0, 1'b1);
            if (i == 28) checkVal("ovf before 4th stuff", 32'(obsOvf), 0);
            if (i == 29) checkVal("ovf at 4th stuff", 32'(obsOvf), 1);
        end
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1, 1'b0);
        se0Seen    = 0;
        ovfDropped = 0;
        guard      = 0;
        while (obsPins[2] == 1'b1 && guard < 40) begin
            strobe(1'b0, 1'b0, 1'b0);
            if (obsPins == PIN_SE0) se0Seen++;
            if (!obsOvf) ovfDropped = 1;
            guard++;
        end
        checkVal("ovf pkt released", 32'(obsPins), 32'(PIN_OFF));
        checkVal("ovf sticky through eop", 32'(ovfDropped), 0);
        checkVal("ovf pkt se0 count", 32'(se0Seen), 2);
        checkVal("ovf flag after eop", 32'(obsOvf), 1);
        checkVal("ovf pkt busy end", 32'(obsBusy), 0);

        // Next packet start clears the overflow; then abort mid-data
        strobe(1'b1, 1'b0, 1'b0);
        checkVal("ovf cleared at start", 32'(obsOvf), 0);
        checkVal("abort pkt start pins", 32'(obsPins), 32'(PIN_OFF));
        expQ.delete();
        expStr("KKJ");
        strobeCheck("abort pkt", 1, 1'b1, 1'b0, 1'b1);
        strobeCheck("abort pkt", 2, 1'b1, 1'b0, 1'b0);
        strobeCheck("abort pkt", 3, 1'b1, 1'b0, 1'b1);
        strobe(1'b0, 1'b0, 1'b0);
        checkVal("abort pins", 32'(obsPins), 32'(PIN_OFF));
        checkVal("abort pulse", 32'(obsAbort), 1);
        checkVal("abort pulse width", 32'(obsAbortLate), 0);
        checkVal("abort busy", 32'(obsBusy), 0);
        checkVal("abort state", 32'(dbgState), 0);
        strobe(1'b0, 1'b0, 1'b0);
        checkVal("post abort idle pins", 32'(obsPins), 32'(PIN_OFF));
        checkVal("post abort no pulse", 32'(obsAbort), 0);

        // Packet after abort must not see the flushed bit; reset it mid-packet
        strobe(1'b1, 1'b0, 1'b0);
        checkVal("rst pkt start pins", 32'(obsPins), 32'(PIN_OFF));
        expQ.delete();
        expStr("KJJ");
        strobeCheck("rst pkt", 1, 1'b1, 1'b0, 1'b0);
        strobeCheck("rst pkt", 2, 1'b1, 1'b0, 1'b1);
        strobeCheck("rst pkt", 3, 1'b1, 1'b0, 1'b1);
        @(negedge useClk);
        rst       = 1'b1;
        checkData = 1'b0;
        @(negedge useClk);
        rst = 1'b0;
        checkVal("midrst pins", 32'({dOE, dpOut, dmOut}), 32'(PIN_OFF));
        checkVal("midrst busy", 32'(txBusy), 0);
        checkVal("midrst ovf", 32'(stuffOverflow), 0);
        checkVal("midrst abort", 32'(txAbort), 0);
        checkVal("midrst state", 32'(dbgState), 0);

        // Normal packet after reset
        runPacket("postrst", 64'(4'b1100), 4, {"JJKJ", "00J", "i"});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
